run_monitor: RTL and testbench

- Synthesizable end-of-run monitor for the single-cycle RISC-V CPU system; replaces ad-hoc halt and register-dump logic in benches and on FPGA.
- Watches retired PCs. Halts the run on a PC match, a self-loop, or a retirement timeout.
- On halt, stalls the CPU, walks the register file through the CPU's reg_sel/reg_data debug port, and streams every register out over a valid/ready channel.

---
 rtl/run_monitor.sv | 102 ++++++++++
 tb/tb_run_monitor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_monitor.sv
// End-of-run monitor: watches retired PCs and halts on a PC match, a self-loop or a timeout.
// Once halted it stalls the CPU and streams every register out over a valid/ready channel.
module run_monitor #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                NREG       = 32,
    parameter logic [ADDR_W-1:0] HALT_PC    = ADDR_W'(32'h0000_0048),
    parameter int                CYC_W      = 16,
    parameter int                MAX_CYCLES = 1000,
    localparam int               IDX_W      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [IDX_W-1:0]  reg_sel,
    input  logic [DATA_W-1:0] reg_data,
    output logic              cpu_stall,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [IDX_W-1:0]  dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic [1:0]        halt_cause,
    output logic [ADDR_W-1:0] halt_pc,
    output logic [CYC_W-1:0]  cycle_count,
    output logic              done
);

    typedef enum logic [1:0] {RUN, LOAD, SEND, DONE} state_t;

    localparam logic [1:0] CAUSE_PC   = 2'b01;
    localparam logic [1:0] CAUSE_TMO  = 2'b10;
    localparam logic [1:0] CAUSE_LOOP = 2'b11;

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] last_pc;
    logic              last_pc_vld;

    logic hit_pc, hit_loop, hit_tmo, retire, halt_now, last_word, accept;

    assign retire    = (state == RUN) && pc_valid;
    assign hit_pc    = (pc_in == HALT_PC);
    assign hit_loop  = last_pc_vld && (pc_in == last_pc);
    assign hit_tmo   = (cycle_count == CYC_W'(MAX_CYCLES - 1));
    assign halt_now  = retire && (hit_pc || hit_loop || hit_tmo);
    assign last_word = (idx == IDX_W'(NREG - 1));
    assign accept    = (state == SEND) && dump_ready;

    // Control outputs decode the state register alone, so they never glitch on inputs.
    assign cpu_stall  = (state != RUN);
    assign dump_valid = (state == SEND);
    assign done       = (state == DONE);
    assign reg_sel    = (state == LOAD || state == SEND) ? idx : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            RUN:     if (halt_now) state_n = LOAD;
            LOAD:    state_n = SEND;
            SEND:    if (dump_ready) state_n = last_word ? DONE : LOAD;
            DONE:    state_n = DONE;
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            last_pc     <= '0;
            last_pc_vld <= 1'b0;
            cycle_count <= '0;
            halt_cause  <= 2'b00;
            halt_pc     <= '0;
            dump_idx    <= '0;
            dump_data   <= '0;
        end else begin
            if (retire) begin
                // The halting retirement is counted too; the count saturates instead of wrapping.
                if (cycle_count != {CYC_W{1'b1}}) cycle_count <= cycle_count + CYC_W'(1);
                last_pc     <= pc_in;
                last_pc_vld <= 1'b1;
                if (halt_now) begin
                    halt_cause <= hit_pc ? CAUSE_PC : (hit_loop ? CAUSE_LOOP : CAUSE_TMO);
                    halt_pc    <= pc_in;
                    idx        <= '0;
                end
            end
            if (state == LOAD) begin
                dump_data <= reg_data;
                dump_idx  <= idx;
            end
            if (accept && !last_word) idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: a default instance (HALT_PC=0x48, NREG=32) and a small
// instance (HALT_PC=0x08, MAX_CYCLES=10, NREG=4) share one stimulus stream.
module tb_run_monitor;

    localparam int NREG2 = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_valid;
    logic [31:0] pc_in;
    logic        dump_ready;

    logic [4:0]  reg_sel, dump_idx;
    logic [31:0] reg_data, dump_data, halt_pc;
    logic        cpu_stall, dump_valid, done;
    logic [1:0]  halt_cause;
    logic [15:0] cycle_count;

    logic [1:0]  reg_sel2, dump_idx2;
    logic [31:0] reg_data2, dump_data2, halt_pc2;
    logic        cpu_stall2, dump_valid2, done2;
    logic [1:0]  halt_cause2;
    logic [15:0] cycle_count2;

    // Register file model: rf[i] = i*0x11
    assign reg_data  = 32'(reg_sel) * 32'h11;
    assign reg_data2 = 32'(reg_sel2) * 32'h11;

    run_monitor dut (
        .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc_in(pc_in),
        .reg_sel(reg_sel), .reg_data(reg_data), .cpu_stall(cpu_stall),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
        .dump_data(dump_data), .halt_cause(halt_cause), .halt_pc(halt_pc),
        .cycle_count(cycle_count), .done(done)
    );

    run_monitor #(.HALT_PC(32'h08), .MAX_CYCLES(10), .NREG(NREG2)) dut2 (
        .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc_in(pc_in),
        .reg_sel(reg_sel2), .reg_data(reg_data2), .cpu_stall(cpu_stall2),
        .dump_valid(dump_valid2), .dump_ready(dump_ready), .dump_idx(dump_idx2),
        .dump_data(dump_data2), .halt_cause(halt_cause2), .halt_pc(halt_pc2),
        .cycle_count(cycle_count2), .done(done2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic            sel;    // 0: dut, 1: dut2
        logic [3:0]      n;      // retirements; the last one must halt
        logic [9:0][31:0] pcs;
        logic [1:0]      cause;
        logic [31:0]     hpc;
        logic [15:0]     cnt;
    } scen_t;

    scen_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_reg_sel"}, 64'(reg_sel), 0);
        chk({tag, "_stall"}, 64'(cpu_stall), 0);
        chk({tag, "_valid"}, 64'(dump_valid), 0);
        chk({tag, "_idx"}, 64'(dump_idx), 0);
        chk({tag, "_data"}, 64'(dump_data), 0);
        chk({tag, "_cause"}, 64'(halt_cause), 0);
        chk({tag, "_hpc"}, 64'(halt_pc), 0);
        chk({tag, "_cnt"}, 64'(cycle_count), 0);
        chk({tag, "_done"}, 64'(done), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; pc_valid = 1'b0; pc_in = '0; dump_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic retire_one(input logic [31:0] pc);
        pc_valid = 1'b1; pc_in = pc;
        @(posedge clk); #1;
        pc_valid = 1'b0;
    endtask

    // Called at the sample point right after LOAD entry on dut; ready held high.
    task automatic run_dump();
        int  words = 0;
        int  k = 0;
        bit  fin = 1'b0;
        dump_ready = 1'b1;
        chk("load_entry_valid", 64'(dump_valid), 0);
        while (!fin && k < 200) begin
            @(posedge clk); #1;
            k++;
            if (done) fin = 1'b1;
            else if (dump_valid) begin
                chk("dump_idx", 64'(dump_idx), 64'(words));
                chk("dump_data", 64'(dump_data), 64'(words * 32'h11));
                words++;
            end
        end
        chk("done_latency", 64'(k), 64);
        chk("word_count", 64'(words), 32);
        chk("done_stall", 64'(cpu_stall), 1);
        chk("done_valid", 64'(dump_valid), 0);
    endtask

    function automatic logic [9:0][31:0] lin(input logic [31:0] base, input int n);
        logic [9:0][31:0] p = '0;
        for (int i = 0; i < n; i++) p[i] = base + 32'(4 * i);
        return p;
    endfunction

    function automatic scen_t mk(input logic sel, input int n, input logic [9:0][31:0] pcs,
                                 input logic [1:0] cause, input logic [31:0] hpc, input int cnt);
        scen_t s;
        s.sel = sel; s.n = 4'(n); s.pcs = pcs; s.cause = cause; s.hpc = hpc; s.cnt = 16'(cnt);
        return s;
    endfunction

    initial begin
        logic [9:0][31:0] p;
        logic [1:0]  c_s;
        logic [31:0] h_s, d_s;
        logic [15:0] n_s;
        logic        st_s, dn_s;
        logic [4:0]  i_s;
        int exp_idx, hold, waited;
        bit held7, prev_v, prev_r;
        logic [4:0]  prev_idx;
        logic [31:0] prev_data;

        // Scenario table: PC stream and expected halt record.
        p = lin(32'h0, 3); p[3] = 32'h08;
        tbl[0] = mk(1'b0, 4, p, 2'b11, 32'h08, 4);          // self-loop
        p = '0; p[0] = 32'h48;
        tbl[1] = mk(1'b0, 1, p, 2'b01, 32'h48, 1);          // match on first retirement
        tbl[2] = mk(1'b1, 10, lin(32'h100, 10), 2'b10, 32'h124, 10); // timeout
        p = '0; p[1] = 32'h08;
        tbl[3] = mk(1'b1, 2, p, 2'b01, 32'h08, 2);          // match beats later self-loop
        p = lin(32'h100, 9); p[9] = 32'h08;
        tbl[4] = mk(1'b1, 10, p, 2'b01, 32'h08, 10);        // match + timeout together
        p = lin(32'h100, 9); p[9] = 32'h120;
        tbl[5] = mk(1'b1, 10, p, 2'b11, 32'h120, 10);       // self-loop + timeout together
        p = lin(32'h100, 8); p[8] = 32'h11C;
        tbl[6] = mk(1'b1, 9, p, 2'b11, 32'h11C, 9);         // self-loop just before timeout

        // Reset state, asserted from time zero
        rst = 1'b1; pc_valid = 1'b0; pc_in = '0; dump_ready = 1'b0;
        #1;
        chk_zero("reset");
        @(posedge clk); #1;

        for (int s = 0; s < 7; s++) begin
            do_reset();
            for (int k = 0; k < int'(tbl[s].n); k++) begin
                pc_valid = 1'b1; pc_in = tbl[s].pcs[k];
                @(posedge clk); #1;
                st_s = tbl[s].sel ? cpu_stall2 : cpu_stall;
                if (k < int'(tbl[s].n) - 1) chk($sformatf("s%0d_stall_early", s), 64'(st_s), 0);
            end
            pc_valid = 1'b0;
            st_s = tbl[s].sel ? cpu_stall2 : cpu_stall;
            c_s  = tbl[s].sel ? halt_cause2 : halt_cause;
            h_s  = tbl[s].sel ? halt_pc2 : halt_pc;
            n_s  = tbl[s].sel ? cycle_count2 : cycle_count;
            chk($sformatf("s%0d_stall", s), 64'(st_s), 1);
            chk($sformatf("s%0d_cause", s), 64'(c_s), 64'(tbl[s].cause));
            chk($sformatf("s%0d_hpc", s), 64'(h_s), 64'(tbl[s].hpc));
            chk($sformatf("s%0d_cnt", s), 64'(n_s), 64'(tbl[s].cnt));
            // Let the dump drain and check the final word stays presented
            dump_ready = 1'b1;
            waited = 0;
            dn_s = tbl[s].sel ? done2 : done;
            while (!dn_s && waited < 100) begin
                @(posedge clk); #1;
                waited++;
                dn_s = tbl[s].sel ? done2 : done;
            end
            i_s = tbl[s].sel ? 5'(dump_idx2) : dump_idx;
            d_s = tbl[s].sel ? dump_data2 : dump_data;
            chk($sformatf("s%0d_done", s), 64'(dn_s), 1);
            chk($sformatf("s%0d_last_idx", s), 64'(i_s), tbl[s].sel ? 64'(NREG2 - 1) : 64'd31);
            chk($sformatf("s%0d_last_data", s), 64'(d_s),
                tbl[s].sel ? 64'((NREG2 - 1) * 32'h11) : 64'(31 * 32'h11));
        end

        // Linear run to HALT_PC and full dump
        do_reset();
        for (int k = 0; k <= 18; k++) begin
            pc_valid = 1'b1; pc_in = 32'(4 * k);
            @(posedge clk); #1;
        end
        pc_valid = 1'b0;
        chk("lin_cause", 64'(halt_cause), 1);
        chk("lin_hpc", 64'(halt_pc), 32'h48);
        chk("lin_cnt", 64'(cycle_count), 19);
        chk("lin_stall", 64'(cpu_stall), 1);
        run_dump();

        // Backpressure with a 5-cycle stall at idx 7 and pc_valid noise
        do_reset();
        retire_one(32'h48);
        exp_idx = 0; hold = 0; held7 = 1'b0; prev_v = 1'b0; prev_r = 1'b0;
        prev_idx = '0; prev_data = '0;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (prev_v && prev_r) chk("bp_valid_fall", 64'(dump_valid), 0);
            if (prev_v && !prev_r) begin
                chk("bp_valid_held", 64'(dump_valid), 1);
                chk("bp_idx_stable", 64'(dump_idx), 64'(prev_idx));
                chk("bp_data_stable", 64'(dump_data), 64'(prev_data));
            end else if (dump_valid) begin
                chk("bp_idx", 64'(dump_idx), 64'(exp_idx));
                chk("bp_data", 64'(dump_data), 64'(exp_idx * 32'h11));
            end
            if (dump_valid && dump_idx == 5'd7 && !held7) begin hold = 5; held7 = 1'b1; end
            if (hold > 0) begin dump_ready = 1'b0; hold--; end
            else dump_ready = 1'($urandom_range(0, 1));
            if (dump_valid && dump_ready) exp_idx++;
            pc_valid = 1'($urandom_range(0, 1));
            pc_in = $urandom_range(0, 1) ? 32'h48 : 32'h200;
            prev_v = dump_valid; prev_r = dump_ready; prev_idx = dump_idx; prev_data = dump_data;
            @(posedge clk); #1;
        end
        pc_valid = 1'b0;
        chk("bp_done", 64'(done), 1);
        chk("bp_words", 64'(exp_idx), 32);
        chk("bp_held7", 64'(held7), 1);
        chk("bp_cnt_frozen", 64'(cycle_count), 1);
        chk("bp_cause_kept", 64'(halt_cause), 1);

        // Reset in SEND at idx 12, then a clean second run
        do_reset();
        retire_one(32'h48);
        dump_ready = 1'b1;
        for (int c = 0; c < 200 && !(dump_valid && dump_idx == 5'd12); c++) begin
            @(posedge clk); #1;
        end
        dump_ready = 1'b0;
        chk("mid_reached_12", 64'(dump_idx), 12);
        chk("mid_valid", 64'(dump_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        retire_one(32'h00);
        retire_one(32'h04);
        chk("rerun_stall_early", 64'(cpu_stall), 0);
        retire_one(32'h04);
        chk("rerun_cause", 64'(halt_cause), 3);
        chk("rerun_hpc", 64'(halt_pc), 32'h04);
        chk("rerun_cnt", 64'(cycle_count), 3);
        run_dump();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
